// File: rtl/bus_sync_launcher.sv
`default_nettype none
// ============================================================================
//  Module      : bus_sync_launcher
//  Description : Source-domain sender for a multi-bit bus synchronizer.
//                Captures a word on valid/ready, holds it on tx_bus and runs
//                a four-phase enable/acknowledge handshake with optional
//                timeout abort.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_sync_launcher #(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int MIN_HOLD   = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [BUS_WIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [BUS_WIDTH-1:0] tx_bus,
    output logic                 bus_enable,
    input  logic                 ack_async,
    output logic                 busy,
    output logic                 done_pulse,
    output logic                 timeout_err
);

    // Counters must reach both the hold threshold and the timeout threshold.
    localparam int c_CNT_MAX = (MIN_HOLD > TIMEOUT) ? MIN_HOLD : TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(MIN_HOLD - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT   = {c_CNT_W{1'b1}};
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SETUP    = 2'd1,
        ST_WAIT_ACK = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [NUM_STAGES-1:0] r_ack_sync;
    logic [c_CNT_W-1:0]    r_hold_cnt;
    logic [c_CNT_W-1:0]    r_to_cnt;
    logic                  r_aborted;

    logic                  w_ack_sync;
    logic                  w_hold_met;
    logic                  w_to_hit;

    assign w_ack_sync = r_ack_sync[NUM_STAGES-1];
    assign w_hold_met = (r_hold_cnt >= c_HOLD_LAST);

    // A stale acknowledge still visible in IDLE blocks the next launch.
    assign in_ready = (r_state == ST_IDLE) & ~w_ack_sync & RST;
    assign busy     = (r_state != ST_IDLE);

    generate
        if (TIMEOUT != 0) begin : g_timeout
            localparam logic [c_CNT_W-1:0] c_TO_LAST = c_CNT_W'(TIMEOUT - 1);
            assign w_to_hit = (r_to_cnt == c_TO_LAST);
        end else begin : g_no_timeout
            assign w_to_hit = 1'b0;
        end
    endgenerate

    // Acknowledge level synchronizer; the FSM sees only its last stage.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_ack_sync <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[NUM_STAGES-2:0], ack_async};
        end
    end

    // Handshake FSM with registered bus, enable and status pulses.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            tx_bus      <= '0;
            bus_enable  <= 1'b0;
            done_pulse  <= 1'b0;
            timeout_err <= 1'b0;
            r_hold_cnt  <= '0;
            r_to_cnt    <= '0;
            r_aborted   <= 1'b0;
        end else begin
            done_pulse  <= 1'b0;
            timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        tx_bus  <= in_data;
                        r_state <= ST_SETUP;
                    end
                end
                // Data has been stable for one cycle before the enable rises.
                ST_SETUP: begin
                    bus_enable <= 1'b1;
                    r_hold_cnt <= '0;
                    r_to_cnt   <= '0;
                    r_aborted  <= 1'b0;
                    r_state    <= ST_WAIT_ACK;
                end
                // Ack is checked before timeout so a coincident ack wins.
                ST_WAIT_ACK: begin
                    if (w_ack_sync && w_hold_met) begin
                        bus_enable <= 1'b0;
                        r_state    <= ST_RELEASE;
                    end else if (w_to_hit) begin
                        bus_enable  <= 1'b0;
                        timeout_err <= 1'b1;
                        r_aborted   <= 1'b1;
                        r_state     <= ST_RELEASE;
                    end else begin
                        if (r_hold_cnt != c_CNT_SAT) begin
                            r_hold_cnt <= r_hold_cnt + c_CNT_ONE;
                        end
                        if (r_to_cnt != c_CNT_SAT) begin
                            r_to_cnt <= r_to_cnt + c_CNT_ONE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (!w_ack_sync) begin
                        done_pulse <= ~r_aborted;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_sync_launcher.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_sync_launcher
//  Description : Self-checking bench for bus_sync_launcher with a timing
//                model of each transfer and a model destination.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_sync_launcher;

    localparam int BW = 8;
    localparam int NS = 2;
    localparam int MH = 4;
    localparam int TO = 64;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [BW-1:0] tx_bus;
    logic          bus_enable;
    logic          ack_async = 1'b0;
    logic          busy;
    logic          done_pulse;
    logic          timeout_err;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Model destination: raises ack dst_r observations after seeing enable
    // high, drops it dst_f observations after seeing enable low.
    bit dst_en = 1'b0;
    int dst_r  = 1;
    int dst_f  = 1;
    int en_cnt = 0;
    int lo_cnt = 0;

    logic [BW-1:0] last_word = '0;

    bus_sync_launcher #(
        .BUS_WIDTH (BW),
        .NUM_STAGES(NS),
        .MIN_HOLD  (MH),
        .TIMEOUT   (TO)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx_bus     (tx_bus),
        .bus_enable (bus_enable),
        .ack_async  (ack_async),
        .busy       (busy),
        .done_pulse (done_pulse),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
        cyc++;
        if (dst_en) begin
            if (bus_enable) begin
                lo_cnt = 0;
                en_cnt++;
                if (en_cnt >= dst_r) ack_async = 1'b1;
            end else begin
                en_cnt = 0;
                if (ack_async) begin
                    lo_cnt++;
                    if (lo_cnt >= dst_f) ack_async = 1'b0;
                end
            end
        end
    endtask

    // One complete transfer, called in an observation where in_ready is
    // expected high. Expected timeline is derived from the handshake rules:
    // enable rises 2 cycles after the accept observation, stays high for
    // max(MIN_HOLD, ack latency) capped at TIMEOUT, the block returns to
    // IDLE NUM_STAGES cycles after the destination drops ack.
    task automatic run_transfer(input logic [BW-1:0] word, input int r, input int f,
                                input bit hold_valid, input string tag);
        int c0, e, d, l, idle;
        bit to;
        logic [BW+4:0] got, exp;
        dst_en = 1'b1;
        dst_r  = r;
        dst_f  = f;
        to   = (r + NS > TO);
        d    = to ? TO : ((r + NS > MH) ? (r + NS) : MH);
        c0   = cyc;
        e    = c0 + 2;
        l    = e + d;
        idle = to ? (l + 1) : (l + f + NS);
        n_checks++;
        if (in_ready !== 1'b1)
            $display("FAIL %s accept_ready cyc=%0d got %b want 1", tag, cyc, in_ready);
        else
            n_pass++;
        in_data  = word;
        in_valid = 1'b1;
        while (cyc < idle) begin
            step();
            if (hold_valid) in_data = BW'($urandom);
            else            in_valid = 1'b0;
            exp = {(cyc >= e && cyc < l), (cyc < idle), !(cyc < idle),
                   (cyc == idle && !to), (cyc == l && to), word};
            got = {bus_enable, busy, in_ready, done_pulse, timeout_err, tx_bus};
            n_checks++;
            if (got !== exp)
                $display("FAIL %s cyc=%0d {en,busy,rdy,done,to,tx} got %b_%h want %b_%h",
                         tag, cyc - c0, got[BW+4:BW], got[BW-1:0], exp[BW+4:BW], exp[BW-1:0]);
            else
                n_pass++;
        end
        in_valid  = 1'b0;
        last_word = word;
    endtask

    task automatic test_reset();
        RST      = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h77;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if ({bus_enable, busy, in_ready, done_pulse, timeout_err, tx_bus} !== 13'h0)
                $display("FAIL reset_state cyc=%0d got en=%b busy=%b rdy=%b done=%b to=%b tx=%h want all 0",
                         i, bus_enable, busy, in_ready, done_pulse, timeout_err, tx_bus);
            else
                n_pass++;
        end
        in_valid = 1'b0;
        RST      = 1'b1;
        step();
        n_checks++;
        if ({in_ready, busy, tx_bus} !== {1'b1, 1'b0, 8'h00})
            $display("FAIL reset_release got rdy=%b busy=%b tx=%h want rdy=1 busy=0 tx=00",
                     in_ready, busy, tx_bus);
        else
            n_pass++;
    endtask

    task automatic test_basic();
        run_transfer(8'hA5, 3, 3, 1'b0, "basic");
    endtask

    task automatic test_early_ack();
        run_transfer(8'h5C, 1, 2, 1'b0, "early_ack");
    endtask

    task automatic test_timeout();
        run_transfer(8'hC7, 1000, 1, 1'b0, "timeout");
        run_transfer(8'h81, TO - NS, 1, 1'b0, "ack_at_timeout");
        run_transfer(8'h42, TO - NS - 1, 2, 1'b0, "ack_before_timeout");
    endtask

    task automatic test_back_to_back();
        run_transfer(8'h11, 2, 1, 1'b1, "b2b_first");
        run_transfer(8'h22, 4, 2, 1'b1, "b2b_second");
    endtask

    task automatic test_stale_ack();
        dst_en    = 1'b0;
        ack_async = 1'b1;
        RST       = 1'b0;
        step();
        step();
        RST = 1'b1;
        for (int i = 0; i <= NS; i++) step();
        in_valid = 1'b1;
        in_data  = 8'hEE;
        for (int i = 0; i < 4; i++) begin
            step();
            n_checks++;
            if ({in_ready, busy, tx_bus} !== {1'b0, 1'b0, 8'h00})
                $display("FAIL stale_block cyc=%0d got rdy=%b busy=%b tx=%h want rdy=0 busy=0 tx=00",
                         i, in_ready, busy, tx_bus);
            else
                n_pass++;
        end
        ack_async = 1'b0;
        for (int k = 0; k < NS; k++) begin
            n_checks++;
            if (in_ready !== 1'b0)
                $display("FAIL stale_hold k=%0d got rdy=%b want 0", k, in_ready);
            else
                n_pass++;
            step();
        end
        run_transfer(8'h5A, 2, 2, 1'b0, "after_stale");
    endtask

    task automatic test_reset_mid();
        dst_en = 1'b1;
        dst_r  = 1000;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL midrst_start got rdy=%b want 1", in_ready);
        else n_pass++;
        in_data  = 8'hC3;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        n_checks++;
        if ({bus_enable, busy, tx_bus} !== {1'b1, 1'b1, 8'hC3})
            $display("FAIL midrst_wait got en=%b busy=%b tx=%h want en=1 busy=1 tx=c3",
                     bus_enable, busy, tx_bus);
        else
            n_pass++;
        RST = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            n_checks++;
            if ({bus_enable, busy, in_ready, done_pulse, timeout_err, tx_bus} !== 13'h0)
                $display("FAIL midrst_clear cyc=%0d got en=%b busy=%b rdy=%b done=%b to=%b tx=%h want all 0",
                         i, bus_enable, busy, in_ready, done_pulse, timeout_err, tx_bus);
            else
                n_pass++;
        end
        RST    = 1'b1;
        en_cnt = 0;
        lo_cnt = 0;
        step();
        n_checks++;
        if ({in_ready, busy, done_pulse, timeout_err} !== 4'b1000)
            $display("FAIL midrst_release got rdy=%b busy=%b done=%b to=%b want 1000",
                     in_ready, busy, done_pulse, timeout_err);
        else
            n_pass++;
        run_transfer(8'h3C, 3, 1, 1'b0, "after_midrst");
    endtask

    task automatic test_random();
        int gap;
        for (int t = 0; t < 16; t++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                step();
                n_checks++;
                if ({bus_enable, busy, in_ready, done_pulse, timeout_err, tx_bus} !==
                    {5'b00100, last_word})
                    $display("FAIL rand_idle t=%0d got en=%b busy=%b rdy=%b done=%b to=%b tx=%h want 00100 tx=%h",
                             t, bus_enable, busy, in_ready, done_pulse, timeout_err, tx_bus, last_word);
                else
                    n_pass++;
            end
            run_transfer(BW'($urandom), int'($urandom_range(1, 10)), int'($urandom_range(1, 5)),
                         1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early_ack();
        test_timeout();
        test_back_to_back();
        test_stale_ack();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
